video_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares the single DDR write port among four HDMI input channels in the multi-channel splicing path. Each channel's line FIFO, fed from the HDMI receive/timing stage, raises a request once it holds one full burst. The arbiter grants one channel at a time, issues a burst write command with that channel's frame-buffer address, and streams the burst out of the granted FIFO. It also keeps a per-channel write pointer that restarts on that channel's vsync and wraps at frame size.

---
 rtl/video_wr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_video_wr_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_wr_arbiter.sv
// Round-robin arbiter sharing one DDR burst-write port among four video channel FIFOs.
// Latency: 1 cycle from sampled request to command; 1 cycle from command handshake to first beat.
// Backpressure: cmd held until wr_cmd_ready; beats and FIFO pops stall while wr_data_ready is low.
module video_wr_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 28,
    parameter int unsigned BURST_LEN    = 16,
    parameter int unsigned FRAME_BURSTS = 28800,
    parameter int unsigned BASE_ADDR    = 0,
    parameter int unsigned CH_STRIDE    = 32'h0080_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          ch_vs,
    input  logic [3:0]          ch_req,
    output logic [3:0]          ch_rd_en,
    input  logic [4*DATA_W-1:0] ch_rd_data,
    output logic                wr_cmd_valid,
    input  logic                wr_cmd_ready,
    output logic [ADDR_W-1:0]   wr_cmd_addr,
    output logic [7:0]          wr_cmd_len,
    output logic                wr_data_valid,
    input  logic                wr_data_ready,
    output logic [DATA_W-1:0]   wr_data,
    output logic                wr_data_last,
    output logic [1:0]          grant_ch,
    output logic                busy
);

    localparam int unsigned BEAT_BYTES  = DATA_W / 8;
    localparam int unsigned BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int unsigned BCNT_W      = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          beat_q, beat_d;
    logic [BCNT_W-1:0]   bcnt_q [4];
    logic [BCNT_W-1:0]   bcnt_d [4];
    logic [3:0]          pend_q, pend_d;
    logic [3:0]          vs_q, vs_d;

    logic [3:0]          vs_rise;
    logic [1:0]          pick;
    logic [1:0]          rr_idx;
    logic                pick_found;
    logic [BCNT_W-1:0]   pick_bcnt;
    logic                beat_last;

    // Frame-buffer byte address of burst number bc for channel ch, wrapped to ADDR_W.
    function automatic logic [ADDR_W-1:0] burst_addr(input logic [1:0] ch, input logic [BCNT_W-1:0] bc);
        logic [63:0] a;
        a = 64'(BASE_ADDR) + 64'(ch) * 64'(CH_STRIDE) + 64'(bc) * 64'(BURST_BYTES);
        return a[ADDR_W-1:0];
    endfunction

    assign vs_rise   = ch_vs & ~vs_q;
    assign vs_d      = ch_vs;
    assign beat_last = (beat_q == 8'(BURST_LEN - 1));

    // Round-robin pick: first requesting channel at or after the priority pointer.
    always_comb begin
        pick       = ptr_q;
        pick_found = 1'b0;
        rr_idx     = ptr_q;
        for (int i = 0; i < 4; i++) begin
            rr_idx = ptr_q + 2'(i);
            if (!pick_found && ch_req[rr_idx]) begin
                pick       = rr_idx;
                pick_found = 1'b1;
            end
        end
        // A vsync edge landing in the grant cycle already restarts the frame.
        pick_bcnt = vs_rise[pick] ? '0 : bcnt_q[pick];
    end

    // State register plus datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            beat_q  <= '0;
            pend_q  <= '0;
            vs_q    <= '0;
            for (int n = 0; n < 4; n++) bcnt_q[n] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            pend_q  <= pend_d;
            vs_q    <= vs_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Next-state logic: IDLE -> CMD on any request, CMD -> DATA on handshake, DATA -> IDLE on last beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|ch_req) state_d = CMD;
            CMD:     if (wr_cmd_ready) state_d = DATA;
            DATA:    if (wr_data_ready && beat_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: grant capture, beat counting, per-channel burst pointers and vsync bookkeeping.
    always_comb begin
        ptr_d   = ptr_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        beat_d  = beat_q;
        pend_d  = pend_q;
        bcnt_d  = bcnt_q;

        // Vsync on the channel in flight is deferred so its burst keeps the address it was given.
        for (int n = 0; n < 4; n++) begin
            if (vs_rise[n]) begin
                if (state_q != IDLE && grant_q == 2'(n)) pend_d[n] = 1'b1;
                else                                     bcnt_d[n] = '0;
            end
        end

        case (state_q)
            IDLE: begin
                if (|ch_req) begin
                    grant_d = pick;
                    addr_d  = burst_addr(pick, pick_bcnt);
                    beat_d  = '0;
                end
            end
            DATA: begin
                if (wr_data_ready) begin
                    if (beat_last) begin
                        beat_d  = '0;
                        ptr_d   = grant_q + 2'd1;
                        pend_d[grant_q] = 1'b0;
                        if (bcnt_q[grant_q] == BCNT_W'(FRAME_BURSTS - 1) || pend_q[grant_q] || vs_rise[grant_q])
                            bcnt_d[grant_q] = '0;
                        else
                            bcnt_d[grant_q] = bcnt_q[grant_q] + BCNT_W'(1);
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from state; data path muxes the granted FIFO head.
    always_comb begin
        wr_cmd_valid  = (state_q == CMD);
        wr_data_valid = (state_q == DATA);
        busy          = (state_q != IDLE);
        wr_data_last  = (state_q == DATA) && beat_last;
        wr_cmd_addr   = addr_q;
        grant_ch      = grant_q;
        wr_data       = '0;
        ch_rd_en      = '0;
        if (state_q == DATA) begin
            wr_data           = ch_rd_data[32'(grant_q) * DATA_W +: DATA_W];
            ch_rd_en[grant_q] = wr_data_ready;
        end
    end

    assign wr_cmd_len = 8'(BURST_LEN - 1);

endmodule

// File: tb/tb_video_wr_arbiter.sv
module tb_video_wr_arbiter;

    localparam int DW     = 32;
    localparam int AW     = 28;
    localparam int BL     = 16;
    localparam int FB     = 4;
    localparam int STRIDE = 32'h0080_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       ch_vs = '0;
    logic [3:0]       ch_req = '0;
    logic [3:0]       ch_rd_en;
    logic [4*DW-1:0]  ch_rd_data;
    logic             wr_cmd_valid;
    logic             wr_cmd_ready = 1'b1;
    logic [AW-1:0]    wr_cmd_addr;
    logic [7:0]       wr_cmd_len;
    logic             wr_data_valid;
    logic             wr_data_ready = 1'b1;
    logic [DW-1:0]    wr_data;
    logic             wr_data_last;
    logic [1:0]       grant_ch;
    logic             busy;

    video_wr_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .FRAME_BURSTS(FB),
        .BASE_ADDR(0), .CH_STRIDE(STRIDE)
    ) dut (
        .clk(clk), .rst(rst), .ch_vs(ch_vs), .ch_req(ch_req), .ch_rd_en(ch_rd_en),
        .ch_rd_data(ch_rd_data), .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
        .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len), .wr_data_valid(wr_data_valid),
        .wr_data_ready(wr_data_ready), .wr_data(wr_data), .wr_data_last(wr_data_last),
        .grant_ch(grant_ch), .busy(busy)
    );

    always #5 clk = ~clk;

    // FIFO model: head of channel n is {n, pop count}; advances on each pop.
    logic [23:0] seq [4] = '{default: 24'd0};
    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) if (ch_rd_en[n]) seq[n] <= seq[n] + 24'd1;
    end
    always_comb begin
        ch_rd_data = '0;
        for (int n = 0; n < 4; n++) ch_rd_data[n*DW +: DW] = {8'(n), seq[n]};
    end

    typedef struct {
        logic [1:0]    ch;
        logic [AW-1:0] addr;
    } cmd_t;

    typedef struct {
        logic [3:0]    req;
        logic [1:0]    ch;
        logic [AW-1:0] addr;
    } vec_t;

    cmd_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          last_hs  = 0;
    int          prev_hs  = 0;
    int          n_pops   = 0;
    int          n_beats  = 0;
    int          n_last   = 0;
    int          mon_beat = 0;
    logic        in_burst = 1'b0;
    logic [1:0]  cur_ch   = '0;
    logic [23:0] exp_seq [4] = '{default: 24'd0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int ch, input int addr);
        cmd_t c;
        c.ch   = 2'(ch);
        c.addr = AW'(addr);
        exp_q.push_back(c);
    endtask

    // Scoreboard side: pops expected commands on handshake, checks every beat and FIFO pop.
    task automatic monitor();
        cmd_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                in_burst = 1'b0;
                mon_beat = 0;
            end else begin
                if (wr_cmd_valid && wr_cmd_ready) begin
                    chk("cmd_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("cmd_ch", grant_ch, e.ch);
                        chk("cmd_addr", wr_cmd_addr, e.addr);
                        cur_ch = e.ch;
                    end
                    in_burst = 1'b1;
                    mon_beat = 0;
                    prev_hs  = last_hs;
                    last_hs  = cyc;
                end
                if (wr_data_valid) begin
                    chk("data_in_burst", in_burst, 1);
                    chk("wr_data", wr_data, {6'd0, cur_ch, exp_seq[cur_ch]});
                    chk("data_last", wr_data_last, mon_beat == BL - 1);
                    chk("rd_en", ch_rd_en, wr_data_ready ? (4'(1) << cur_ch) : 4'(0));
                    if (wr_data_ready) begin
                        exp_seq[cur_ch] = exp_seq[cur_ch] + 24'd1;
                        mon_beat++;
                        n_beats++;
                        if (wr_data_last) n_last++;
                        if (mon_beat == BL) in_burst = 1'b0;
                    end
                end else begin
                    chk("rd_en_idle", ch_rd_en, 0);
                end
                for (int n = 0; n < 4; n++) if (ch_rd_en[n]) n_pops++;
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {wr_cmd_valid, wr_data_valid, wr_data_last, ch_rd_en, grant_ch, busy}, 0);
        chk({tag, "_addr"}, wr_cmd_addr, 0);
        chk({tag, "_data"}, wr_data, 0);
        chk({tag, "_len"}, wr_cmd_len, BL - 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            ch_req        = 4'($urandom);
            ch_vs         = 4'($urandom);
            wr_cmd_ready  = 1'($urandom);
            wr_data_ready = 1'($urandom);
            @(negedge clk);
            if (i == 9) chk_zero("rst");
        end
        @(posedge clk); #2;
        ch_req = '0; ch_vs = '0; wr_cmd_ready = 1'b1; wr_data_ready = 1'b1;
        exp_q.delete();
        @(posedge clk); #2;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        chk_zero("post_rst");
    endtask

    // One-cycle request pulse, issued from IDLE.
    task automatic issue(input logic [3:0] r);
        @(posedge clk); #2;
        ch_req = r;
        @(posedge clk); #2;
        ch_req = '0;
    endtask

    task automatic wait_done(input int bound, input bit alt);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < bound) begin
            @(posedge clk); #2;
            if (alt) wr_data_ready = ~wr_data_ready;
            k++;
        end
        chk("done_in_time", k < bound, 1);
    endtask

    initial begin
        vec_t tbl [11];
        int   cnt;
        int   pops0;
        int   beats0;
        int   last0;

        // Starting after reset: ptr=0, all burst counters 0, frame of 4 bursts.
        tbl[0]  = '{4'b0001, 2'd0, 28'h000_0000};
        tbl[1]  = '{4'b0001, 2'd0, 28'h000_0040};
        tbl[2]  = '{4'b1111, 2'd1, 28'h080_0000};
        tbl[3]  = '{4'b0011, 2'd0, 28'h000_0080};
        tbl[4]  = '{4'b1001, 2'd3, 28'h180_0000};
        tbl[5]  = '{4'b1010, 2'd1, 28'h080_0040};
        tbl[6]  = '{4'b0101, 2'd2, 28'h100_0000};
        tbl[7]  = '{4'b0001, 2'd0, 28'h000_00C0};
        tbl[8]  = '{4'b0001, 2'd0, 28'h000_0000};
        tbl[9]  = '{4'b1100, 2'd2, 28'h100_0040};
        tbl[10] = '{4'b1100, 2'd3, 28'h180_0040};

        fork
            monitor();
        join_none

        // Single request: latency, burst length, busy span (CMD + 16 beats).
        do_reset();
        push(0, 0);
        pops0 = n_pops; beats0 = n_beats; last0 = n_last;
        @(posedge clk); #2;
        ch_req = 4'b0001;
        @(posedge clk); #2;
        ch_req = '0;
        @(negedge clk);
        chk("req_to_cmd", wr_cmd_valid, 1);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("busy_cycles", cnt, BL + 1);
        chk("single_pops", n_pops - pops0, BL);
        chk("single_beats", n_beats - beats0, BL);
        chk("single_last", n_last - last0, 1);
        push(0, 32'h40);
        issue(4'b0001);
        wait_done(60, 1'b0);

        // Table-driven round-robin and address sequence.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            push(int'(tbl[i].ch), int'(tbl[i].addr));
            issue(tbl[i].req);
            wait_done(60, 1'b0);
            chk("tbl_grant", grant_ch, tbl[i].ch);
        end

        // All channels requesting continuously.
        do_reset();
        push(0, 0); push(1, STRIDE); push(2, 2 * STRIDE); push(3, 3 * STRIDE); push(0, 32'h40);
        @(posedge clk); #2;
        ch_req = 4'hF;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 200) begin
            @(posedge clk); #2;
            cnt++;
        end
        chk("rr_cmds_in_time", cnt < 200, 1);
        ch_req = '0;
        wait_done(60, 1'b0);
        chk("burst_period", last_hs - prev_hs, BL + 2);

        // Command backpressure then alternating data ready.
        do_reset();
        wr_cmd_ready = 1'b0;
        push(0, 0);
        pops0 = n_pops; beats0 = n_beats;
        issue(4'b0001);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_cmd_valid", wr_cmd_valid, 1);
            chk("bp_cmd_addr", wr_cmd_addr, 0);
        end
        @(posedge clk); #2;
        wr_cmd_ready = 1'b1;
        wait_done(80, 1'b1);
        wr_data_ready = 1'b1;
        chk("bp_pops", n_pops - pops0, BL);
        chk("bp_beats", n_beats - beats0, BL);

        // Frame wrap, vsync during a burst, vsync while idle.
        do_reset();
        for (int b = 0; b < 5; b++) begin
            push(1, STRIDE + (b % FB) * 64);
            issue(4'b0010);
            wait_done(60, 1'b0);
        end
        push(1, STRIDE + 32'h40);
        issue(4'b0010);
        cnt = 0;
        while (!wr_data_valid && cnt < 20) begin
            @(posedge clk); #2;
            cnt++;
        end
        chk("vs_reach_data", wr_data_valid, 1);
        ch_vs = 4'b0010;
        @(posedge clk); #2;
        @(posedge clk); #2;
        ch_vs = '0;
        wait_done(60, 1'b0);
        push(1, STRIDE);
        issue(4'b0010);
        wait_done(60, 1'b0);
        @(posedge clk); #2;
        ch_vs = 4'b0010;
        @(posedge clk); #2;
        ch_vs = '0;
        push(1, STRIDE);
        issue(4'b0010);
        wait_done(60, 1'b0);
        push(1, STRIDE + 32'h40);
        issue(4'b0010);
        wait_done(60, 1'b0);

        // Reset after 7 accepted beats, then restart from ptr=0 and address 0.
        do_reset();
        push(0, 0);
        issue(4'b0001);
        wait_done(60, 1'b0);
        push(1, STRIDE);
        issue(4'b0010);
        wait_done(60, 1'b0);
        push(0, 32'h40);
        issue(4'b0001);
        cnt = 0;
        while (!(mon_beat == 7 && wr_data_valid) && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("midrst_reached", cnt < 40, 1);
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk); #2;
        @(posedge clk); #2;
        exp_q.delete();
        rst = 1'b1;
        push(0, 0);
        issue(4'hF);
        wait_done(60, 1'b0);
        push(1, STRIDE);
        issue(4'hF);
        wait_done(60, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
